// File: rtl/noc_local_injector_if.sv
// rtl/noc_local_injector_if.sv - request, payload and flit streams between local core, injector and router
interface noc_local_injector_if #(
    parameter int X_NODE_NUM_WIDTH = 2,
    parameter int Y_NODE_NUM_WIDTH = 2,
    parameter int LEN_WIDTH        = 4
);
    logic                        req_valid;
    logic                        req_ready;
    logic [X_NODE_NUM_WIDTH-1:0] req_dest_x;
    logic [Y_NODE_NUM_WIDTH-1:0] req_dest_y;
    logic [LEN_WIDTH-1:0]        req_len;
    logic                        data_valid;
    logic [7:0]                  data_in;
    logic                        data_ready;
    logic                        flit_valid;
    logic [9:0]                  flit_out;
    logic                        flit_ready;

    modport master (
        output req_valid, req_dest_x, req_dest_y, req_len, data_valid, data_in, flit_ready,
        input  req_ready, data_ready, flit_valid, flit_out
    );

    modport slave (
        input  req_valid, req_dest_x, req_dest_y, req_len, data_valid, data_in, flit_ready,
        output req_ready, data_ready, flit_valid, flit_out
    );
endinterface

// File: rtl/noc_local_injector.sv
// rtl/noc_local_injector.sv - local-port packetiser: request + byte stream in, header/body/tail flits out
module noc_local_injector #(
    parameter int SRC_X            = 2,
    parameter int SRC_Y            = 3,
    parameter int X_NODE_NUM_WIDTH = 2,
    parameter int Y_NODE_NUM_WIDTH = 2,
    parameter int LEN_WIDTH        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    noc_local_injector_if.slave  bus,
    output logic                 err_self,
    output logic                 err_len,
    output logic [7:0]           pkt_count
);
    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b01;

    localparam logic [X_NODE_NUM_WIDTH-1:0] SRC_X_V = X_NODE_NUM_WIDTH'(SRC_X);
    localparam logic [Y_NODE_NUM_WIDTH-1:0] SRC_Y_V = Y_NODE_NUM_WIDTH'(SRC_Y);

    typedef enum logic {IDLE, BODY} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic                 flit_valid_q;
    logic [9:0]           flit_q;

    logic       load;
    logic       req_fire;
    logic       data_fire;
    logic       dest_self;
    logic       len_zero;
    logic       hdr_load;
    logic       last_flit;
    logic [7:0] header;

    // Output register may take a new flit when empty or when its current flit leaves this cycle.
    assign load      = !flit_valid_q || bus.flit_ready;
    assign req_fire  = bus.req_valid && bus.req_ready;
    assign data_fire = bus.data_valid && bus.data_ready;
    assign dest_self = (bus.req_dest_x == SRC_X_V) && (bus.req_dest_y == SRC_Y_V);
    assign len_zero  = (bus.req_len == '0);
    assign hdr_load  = req_fire && !dest_self && !len_zero;
    assign last_flit = (remaining_q == LEN_WIDTH'(1));
    // Destination sits in the low bits so the router's route compute reads it directly.
    assign header    = 8'({SRC_Y_V, SRC_X_V, bus.req_dest_y, bus.req_dest_x});

    assign bus.flit_valid = flit_valid_q;
    assign bus.flit_out   = flit_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hdr_load) state_d = BODY;
            BODY:    if (data_fire && last_flit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.data_ready = 1'b0;
        case (state_q)
            IDLE:    bus.req_ready  = load;
            BODY:    bus.data_ready = load;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flit_valid_q <= 1'b0;
            flit_q       <= '0;
            remaining_q  <= '0;
            err_self     <= 1'b0;
            err_len      <= 1'b0;
            pkt_count    <= '0;
        end else begin
            // Self-addressing wins when a request is both self-addressed and empty.
            err_self <= req_fire && dest_self;
            err_len  <= req_fire && !dest_self && len_zero;

            if (flit_valid_q && bus.flit_ready && (flit_q[9:8] == FT_TAIL)) begin
                pkt_count <= pkt_count + 8'd1;
            end

            if (load) begin
                if (hdr_load) begin
                    flit_valid_q <= 1'b1;
                    flit_q       <= {FT_HEAD, header};
                end else if (data_fire) begin
                    flit_valid_q <= 1'b1;
                    flit_q       <= {(last_flit ? FT_TAIL : FT_BODY), bus.data_in};
                end else begin
                    flit_valid_q <= 1'b0;
                end
            end

            if (hdr_load) begin
                remaining_q <= bus.req_len;
            end else if (data_fire) begin
                remaining_q <= remaining_q - LEN_WIDTH'(1);
            end
        end
    end
endmodule
